// File: rtl/sigmoid_q4_12_if.sv
// Sample stream bundle for the Q4.12 sigmoid core: operand in, result out.
// The master drives operands and receives results; the core is the slave.
interface sigmoid_q4_12_if;
    logic        in_valid;
    logic [15:0] x;
    logic        out_valid;
    logic [15:0] y;

    modport master (
        output in_valid,
        output x,
        input  out_valid,
        input  y
    );

    modport slave (
        input  in_valid,
        input  x,
        output out_valid,
        output y
    );
endinterface

// File: rtl/sigmoid_q4_12.sv
// Three-stage PLAN piecewise-linear sigmoid on Q4.12 samples, shifts and adds only.
// Define SIGMOID_RND_EN to make the stage-2 shifts round to nearest (ties up).
module sigmoid_q4_12 (
    input  logic               clk,
    input  logic               rst_n,
    sigmoid_q4_12_if.slave     bus
);

    typedef enum logic [1:0] {
        SEG0 = 2'd0,
        SEG1 = 2'd1,
        SEG2 = 2'd2,
        SEG3 = 2'd3
    } seg_e;

`ifdef SIGMOID_RND_EN
    localparam logic [16:0] RND_S0 = 17'd2;
    localparam logic [16:0] RND_S1 = 17'd4;
    localparam logic [16:0] RND_S2 = 17'd16;
`else
    localparam logic [16:0] RND_S0 = 17'd0;
    localparam logic [16:0] RND_S1 = 17'd0;
    localparam logic [16:0] RND_S2 = 17'd0;
`endif

    localparam logic [16:0] A_S3 = 17'h05000;
    localparam logic [16:0] A_S2 = 17'h02600;
    localparam logic [16:0] A_S1 = 17'h01000;

    logic        v1_q, v1_d;
    logic        neg1_q, neg1_d;
    logic [16:0] abs1_q, abs1_d;
    seg_e        seg1_q, seg1_d;

    logic        v2_q, v2_d;
    logic        neg2_q, neg2_d;
    logic [12:0] p2_q, p2_d;

    logic        v3_q, v3_d;
    logic [15:0] y_q, y_d;

    logic [16:0]        x_ext;
    logic signed [16:0] res_s;

    // Magnitude is one bit wider than x so that -32768 has a representable |x|.
    always_comb begin
        v1_d   = bus.in_valid;
        neg1_d = bus.x[15];
        x_ext  = {bus.x[15], bus.x};
        abs1_d = neg1_d ? (17'd0 - x_ext) : x_ext;
        if (abs1_d >= A_S3) begin
            seg1_d = SEG3;
        end else if (abs1_d >= A_S2) begin
            seg1_d = SEG2;
        end else if (abs1_d >= A_S1) begin
            seg1_d = SEG1;
        end else begin
            seg1_d = SEG0;
        end
    end

    always_comb begin
        v2_d   = v1_q;
        neg2_d = neg1_q;
        p2_d   = 13'h1000;
        case (seg1_q)
            SEG0:    p2_d = 13'((abs1_q + RND_S0) >> 2) + 13'h0800;
            SEG1:    p2_d = 13'((abs1_q + RND_S1) >> 3) + 13'h0A00;
            SEG2:    p2_d = 13'((abs1_q + RND_S2) >> 5) + 13'h0D80;
            default: p2_d = 13'h1000;
        endcase
    end

    // Negative inputs mirror about 0.5; the result is held between valid samples.
    always_comb begin
        v3_d  = v2_q;
        res_s = neg2_q ? (17'sh01000 - $signed({4'b0000, p2_q}))
                       : $signed({4'b0000, p2_q});
        y_d   = y_q;
        if (v2_q) begin
            if (res_s < 17'sh00000) begin
                y_d = 16'h0000;
            end else if (res_s > 17'sh01000) begin
                y_d = 16'h1000;
            end else begin
                y_d = res_s[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            neg1_q <= 1'b0;
            abs1_q <= 17'd0;
            seg1_q <= SEG0;
            v2_q   <= 1'b0;
            neg2_q <= 1'b0;
            p2_q   <= 13'd0;
            v3_q   <= 1'b0;
            y_q    <= 16'h0000;
        end else begin
            v1_q   <= v1_d;
            neg1_q <= neg1_d;
            abs1_q <= abs1_d;
            seg1_q <= seg1_d;
            v2_q   <= v2_d;
            neg2_q <= neg2_d;
            p2_q   <= p2_d;
            v3_q   <= v3_d;
            y_q    <= y_d;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_sigmoid_q4_12.sv
// Self-checking bench for sigmoid_q4_12: directed literals, random stream, full sweep.
// Build with +define+SIGMOID_RND_EN to check the rounding variant.
module tb_sigmoid_q4_12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sigmoid_q4_12_if bus ();

    sigmoid_q4_12 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef SIGMOID_RND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    int checks = 0;
    int errors = 0;

    logic        check_en = 1'b0;
    logic        sweep_on = 1'b0;
    logic [15:0] cap_q[$];

    logic [15:0] dx[11] = '{16'h0800, 16'h1000, 16'h2600, 16'h4000,
                            16'hF000, 16'hF800, 16'hDA00,
                            16'h5000, 16'h7FFF, 16'hB000, 16'h8000};
    logic [15:0] dy[11] = '{16'h0A00, 16'h0C00, 16'h0EB0, 16'h0F80,
                            16'h0400, 16'h0600, 16'h0150,
                            16'h1000, 16'h1000, 16'h0000, 16'h0000};

    // Reference sigmoid from the segment rules, using plain integer arithmetic.
    function automatic logic [15:0] golden(input logic [15:0] xin);
        int xs, a, p, r;
        xs = int'($signed(xin));
        a  = (xs < 0) ? -xs : xs;
        if (a >= 20480)     p = 4096;
        else if (a >= 9728) p = (a + RND * 16) / 32 + 3456;
        else if (a >= 4096) p = (a + RND * 4) / 8 + 2560;
        else                p = (a + RND * 2) / 4 + 2048;
        r = (xs < 0) ? (4096 - p) : p;
        if (r < 0)    r = 0;
        if (r > 4096) r = 4096;
        return 16'(r);
    endfunction

    function automatic int seg_id(input logic [15:0] xin);
        int xs, a, s;
        xs = int'($signed(xin));
        a  = (xs < 0) ? -xs : xs;
        s  = (a >= 20480) ? 3 : (a >= 9728) ? 2 : (a >= 4096) ? 1 : 0;
        return ((xs < 0) ? 4 : 0) + s;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] xin);
        @(posedge clk);
        #1;
        bus.in_valid = valid;
        bus.x        = xin;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000);
    endtask

    // Model: a three-deep delay line of (valid, expected y, x) with a held output.
    logic [2:0]  mv;
    logic [15:0] me0, me1, mx0, mx1, my, mxo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv  <= 3'b000;
            me0 <= 16'h0000;
            me1 <= 16'h0000;
            mx0 <= 16'h0000;
            mx1 <= 16'h0000;
            my  <= 16'h0000;
            mxo <= 16'h0000;
        end else begin
            mv  <= {mv[1:0], bus.in_valid};
            me0 <= golden(bus.x);
            me1 <= me0;
            mx0 <= bus.x;
            mx1 <= mx0;
            if (mv[1]) begin
                my  <= me1;
                mxo <= mx1;
            end
        end
    end

    int          prev_seg = -1;
    logic [15:0] prev_y   = 16'h0000;

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("out_valid", int'(bus.out_valid), int'(mv[2]));
            checkOutput("y", int'(bus.y), int'(my));
            if (bus.out_valid) begin
                cap_q.push_back(bus.y);
                if (sweep_on) begin
                    checkOutput("range", int'(bus.y > 16'h1000), 0);
                    if (seg_id(mxo) == prev_seg)
                        checkOutput("monotonic", int'(bus.y < prev_y), 0);
                    prev_seg <= seg_id(mxo);
                    prev_y   <= bus.y;
                end
            end
            if (!sweep_on) prev_seg <= -1;
        end
    end

    task automatic runGroup(input string name, input int lo, input int hi);
        cap_q.delete();
        for (int i = lo; i <= hi; i++) begin
            checkOutput("model_pin", int'(golden(dx[i])), int'(dy[i]));
            applyStimulus(1'b1, dx[i]);
        end
        idle(5);
        checkOutput({name, "_count"}, cap_q.size(), hi - lo + 1);
        for (int i = lo; i <= hi; i++) begin
            if (i - lo < cap_q.size())
                checkOutput(name, int'(cap_q[i - lo]), int'(dy[i]));
        end
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] rnd_exp;
        bus.in_valid = 1'b0;
        bus.x        = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_y", int'(bus.y), 0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        $display("[TB] latency and zero");
        applyStimulus(1'b1, 16'h0000);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_c1", int'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput("lat_c2", int'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput("lat_c3", int'(bus.out_valid), 1);
        checkOutput("lat_y", int'(bus.y), 16'h0800);
        @(negedge clk);
        checkOutput("lat_c4", int'(bus.out_valid), 0);
        checkOutput("hold_y", int'(bus.y), 16'h0800);
        idle(2);

        $display("[TB] directed segment, symmetry and saturation points");
        runGroup("segment", 0, 3);
        runGroup("negative", 4, 6);
        runGroup("saturate", 7, 10);

        rnd_exp = (RND == 1) ? 16'h0801 : 16'h0800;
        cap_q.delete();
        checkOutput("model_pin_rnd", int'(golden(16'h0003)), int'(rnd_exp));
        applyStimulus(1'b1, 16'h0003);
        idle(5);
        checkOutput("rounding_count", cap_q.size(), 1);
        if (cap_q.size() > 0) checkOutput("rounding", int'(cap_q[0]), int'(rnd_exp));

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'($urandom));
        checkOutput("pre_reset_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", int'(bus.out_valid), 0);
        checkOutput("async_reset_y", int'(bus.y), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("post_reset_stale", int'(bus.out_valid), 0);
        end

        $display("[TB] random stream");
        for (int i = 0; i < 2000; i++) begin
            rx = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rx = dx[$urandom_range(0, 10)] + 16'($urandom_range(0, 2)) - 16'd1;
            applyStimulus(($urandom_range(0, 9) < 7), rx);
        end
        idle(5);

        $display("[TB] exhaustive sweep");
        sweep_on = 1'b1;
        for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 16'h8000 + 16'(i));
        idle(5);
        sweep_on = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
